// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, sizes and small
// helpers used by the decode/issue stage and its decoder.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    function automatic logic [XLEN-1:0] make_imm(input logic [XLEN-1:0] instr,
                                                 input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{instr[31]}}, instr[31:20]};
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   return {instr[31:12], 12'h000};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return {XLEN{1'b0}};
        endcase
    endfunction

    function automatic logic [NREG-1:0] reg_onehot(input logic [4:0] r);
        return NREG'(1) << r;
    endfunction

endpackage

// File: rtl/id_issue_stage_rv_decoder.sv
// Purely combinational RV32I field/immediate decoder (module rv_decoder).
// Unused sources and non-writing destinations are reported as register 0.
module rv_decoder
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    imm_fmt_e fmt_s;
    logic     rd_writer_s;

    // opcode class -> operand usage and immediate format
    always_comb begin
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        rd_writer_s = 1'b0;
        fmt_s       = IMM_NONE;
        illegal     = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin fmt_s = IMM_U; rd_writer_s = 1'b1; end
            OPC_JAL:            begin fmt_s = IMM_J; rd_writer_s = 1'b1; end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                fmt_s = IMM_I; uses_rs1 = 1'b1; rd_writer_s = 1'b1;
            end
            OPC_BRANCH: begin fmt_s = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_STORE:  begin fmt_s = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_OP: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; rd_writer_s = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        writes = rd_writer_s && (instr[11:7] != 5'd0);
        rs1    = uses_rs1 ? instr[19:15] : 5'd0;
        rs2    = uses_rs2 ? instr[24:20] : 5'd0;
        rd     = writes   ? instr[11:7]  : 5'd0;
        imm    = make_imm(instr, fmt_s);
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: one-entry hold register, scoreboard-based RAW stall and
// registered issue toward execute. Define ID_WB_BYPASS_EN to let a source being
// written back this cycle count as ready.
module id_issue_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    input  logic            flush,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_pc,
    output logic [6:0]      ex_opcode,
    output logic [3:0]      ex_funct,
    output logic [4:0]      ex_rd,
    output logic            ex_rw,
    output logic [31:0]     ex_imm,
    output logic            ex_illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);

    logic            hold_full_q, hold_full_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [6:0]      ex_opcode_q, ex_opcode_d;
    logic [3:0]      ex_funct_q, ex_funct_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_rw_q, ex_rw_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic            ex_illegal_q, ex_illegal_d;
    logic [NREG-1:0] sb_q, sb_d;

    logic            dec_uses_rs1_s, dec_uses_rs2_s, dec_writes_s, dec_illegal_s;
    logic [4:0]      dec_rs1_s, dec_rs2_s, dec_rd_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [NREG-1:0] busy_s;
    logic            hazard_s, issue_s, accept_s, if_ready_s;

    rv_decoder u_dec (
        .instr    (hold_instr_q),
        .uses_rs1 (dec_uses_rs1_s),
        .uses_rs2 (dec_uses_rs2_s),
        .writes   (dec_writes_s),
        .rs1      (dec_rs1_s),
        .rs2      (dec_rs2_s),
        .rd       (dec_rd_s),
        .imm      (dec_imm_s),
        .illegal  (dec_illegal_s)
    );

    // hazard detection and issue/accept handshake
    always_comb begin
`ifdef ID_WB_BYPASS_EN
        busy_s = wb_valid ? (sb_q & ~reg_onehot(wb_rd)) : sb_q;
`else
        busy_s = sb_q;
`endif
        hazard_s   = (dec_uses_rs1_s && (dec_rs1_s != 5'd0) && busy_s[dec_rs1_s]) ||
                     (dec_uses_rs2_s && (dec_rs2_s != 5'd0) && busy_s[dec_rs2_s]);
        issue_s    = hold_full_q && !hazard_s && !flush && (!ex_valid_q || ex_ready);
        if_ready_s = (!hold_full_q || issue_s) && !flush;
        accept_s   = if_valid && if_ready_s;
    end

    // next-state for hold register, execute outputs and scoreboard
    always_comb begin
        hold_full_d  = hold_full_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_opcode_d  = ex_opcode_q;
        ex_funct_d   = ex_funct_q;
        ex_rd_d      = ex_rd_q;
        ex_rw_d      = ex_rw_q;
        ex_imm_d     = ex_imm_q;
        ex_illegal_d = ex_illegal_q;
        sb_d         = sb_q;

        if (accept_s) begin
            hold_full_d  = 1'b1;
            hold_instr_d = if_instr;
            hold_pc_d    = if_pc;
        end else if (issue_s || flush) begin
            hold_full_d  = 1'b0;
        end else begin
            hold_full_d  = hold_full_q;
        end

        if (issue_s) begin
            ex_valid_d   = 1'b1;
            ex_pc_d      = hold_pc_q;
            ex_opcode_d  = hold_instr_q[6:0];
            ex_funct_d   = {hold_instr_q[30], hold_instr_q[14:12]};
            ex_rd_d      = dec_rd_s;
            ex_rw_d      = dec_writes_s;
            ex_imm_d     = dec_imm_s;
            ex_illegal_d = dec_illegal_s;
        end else if (ex_ready) begin
            ex_valid_d   = 1'b0;
        end else begin
            ex_valid_d   = ex_valid_q;
        end

        // clear before set: a younger writer of the same register keeps it busy
        if (wb_valid) begin
            sb_d = sb_d & ~reg_onehot(wb_rd);
        end else begin
            sb_d = sb_q;
        end
        if (issue_s && dec_writes_s) begin
            sb_d = sb_d | reg_onehot(dec_rd_s);
        end else begin
            sb_d = sb_d;
        end
        sb_d[0] = 1'b0;
    end

    // state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full_q  <= 1'b0;
            hold_instr_q <= {XLEN{1'b0}};
            hold_pc_q    <= {XLEN{1'b0}};
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= {XLEN{1'b0}};
            ex_opcode_q  <= 7'd0;
            ex_funct_q   <= 4'd0;
            ex_rd_q      <= 5'd0;
            ex_rw_q      <= 1'b0;
            ex_imm_q     <= {XLEN{1'b0}};
            ex_illegal_q <= 1'b0;
            sb_q         <= {NREG{1'b0}};
        end else begin
            hold_full_q  <= hold_full_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_funct_q   <= ex_funct_d;
            ex_rd_q      <= ex_rd_d;
            ex_rw_q      <= ex_rw_d;
            ex_imm_q     <= ex_imm_d;
            ex_illegal_q <= ex_illegal_d;
            sb_q         <= sb_d;
        end
    end

    assign if_ready   = if_ready_s;
    assign rf_rs1     = hold_full_q ? dec_rs1_s : 5'd0;
    assign rf_rs2     = hold_full_q ? dec_rs2_s : 5'd0;
    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_opcode  = ex_opcode_q;
    assign ex_funct   = ex_funct_q;
    assign ex_rd      = ex_rd_q;
    assign ex_rw      = ex_rw_q;
    assign ex_imm     = ex_imm_q;
    assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: decode vector table, directed
// multi-cycle corner cases and a randomized run against a reference model.
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid, if_ready, flush, ex_valid, ex_ready, ex_rw, ex_illegal, wb_valid;
    logic [31:0] if_instr, if_pc, ex_pc, ex_imm;
    logic [4:0]  rf_rs1, rf_rs2, ex_rd, wb_rd;
    logic [6:0]  ex_opcode;
    logic [3:0]  ex_funct;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_issue_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_rd(ex_rd),
        .ex_rw(ex_rw), .ex_imm(ex_imm), .ex_illegal(ex_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic        rw;
        logic [31:0] imm;
        logic [3:0]  funct;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        u1, u2, wr, ill;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
    } dec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        tick();
        wb_valid = 1'b0;
    endtask

    // Instruction semantics from the ISA tables, immediates via signed arithmetic.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   s;
        logic writer;
        s      = $signed(w);
        d.u1   = 1'b0; d.u2 = 1'b0; d.ill = 1'b0; writer = 1'b0; d.imm = 32'd0;
        case (w[6:0])
            7'h37, 7'h17: begin writer = 1'b1; d.imm = w & 32'hFFFF_F000; end
            7'h6F: begin
                writer = 1'b1;
                d.imm  = 32'((s >>> 31) * 1048576 + int'(w[19:12]) * 4096 +
                             int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            end
            7'h67, 7'h03, 7'h13: begin writer = 1'b1; d.u1 = 1'b1; d.imm = 32'(s >>> 20); end
            7'h63: begin
                d.u1 = 1'b1; d.u2 = 1'b1;
                d.imm = 32'((s >>> 31) * 4096 + int'(w[7]) * 2048 +
                            int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            end
            7'h23: begin d.u1 = 1'b1; d.u2 = 1'b1; d.imm = 32'((s >>> 25) * 32 + int'(w[11:7])); end
            7'h33: begin writer = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
            default: d.ill = 1'b1;
        endcase
        d.rs1 = d.u1 ? w[19:15] : 5'd0;
        d.rs2 = d.u2 ? w[24:20] : 5'd0;
        d.wr  = writer && (w[11:7] != 5'd0);
        d.rd  = d.wr ? w[11:7] : 5'd0;
        return d;
    endfunction

    // reference model state
    logic        m_held, m_exv, m_rw, m_ill, hz, iss, ifr;
    logic [31:0] m_hi, m_hp, m_pc, m_imm, m_busy, eff, w;
    logic [6:0]  m_op;
    logic [3:0]  m_fn;
    logic [4:0]  m_rd;
    dec_t        md;
    logic [6:0]  ops [11];

    initial begin
        vecs[0]  = '{32'h00500093, 5'd0, 5'd0, 5'd1, 1'b1, 32'h00000005, 4'h0, 1'b0};
        vecs[1]  = '{32'h00108133, 5'd1, 5'd1, 5'd2, 1'b1, 32'h00000000, 4'h0, 1'b0};
        vecs[2]  = '{32'h00100013, 5'd0, 5'd0, 5'd0, 1'b0, 32'h00000001, 4'h0, 1'b0};
        vecs[3]  = '{32'h123452B7, 5'd0, 5'd0, 5'd5, 1'b1, 32'h12345000, 4'h5, 1'b0};
        vecs[4]  = '{32'hFFFFF317, 5'd0, 5'd0, 5'd6, 1'b1, 32'hFFFFF000, 4'hF, 1'b0};
        vecs[5]  = '{32'hFFDFF0EF, 5'd0, 5'd0, 5'd1, 1'b1, 32'hFFFFFFFC, 4'hF, 1'b0};
        vecs[6]  = '{32'h008183E7, 5'd3, 5'd0, 5'd7, 1'b1, 32'h00000008, 4'h0, 1'b0};
        vecs[7]  = '{32'hFE208CE3, 5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFFFFF8, 4'h8, 1'b0};
        vecs[8]  = '{32'hFFC12183, 5'd2, 5'd0, 5'd3, 1'b1, 32'hFFFFFFFC, 4'hA, 1'b0};
        vecs[9]  = '{32'h00532623, 5'd6, 5'd5, 5'd0, 1'b0, 32'h0000000C, 4'h2, 1'b0};
        vecs[10] = '{32'h40628233, 5'd5, 5'd6, 5'd4, 1'b1, 32'h00000000, 4'h8, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1'b0, 32'h00000000, 4'hF, 1'b1};
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B};

        reset = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; flush = 1'b0;
        ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_if_ready", {31'd0, if_ready}, 32'd1);
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_fields", {ex_rd, ex_rw, ex_illegal, ex_opcode, ex_funct}, 32'd0);
        check("rst_ex_pc_imm", ex_pc | ex_imm, 32'd0);
        check("rst_rf", {22'd0, rf_rs1, rf_rs2}, 32'd0);
        tick();

        // decode table, one instruction at a time
        for (int i = 0; i < 12; i++) begin
            w = vecs[i].instr;
            send(w, 32'h1000 + 32'(i * 4));
            check("vec_rf_rs1", {27'd0, rf_rs1}, {27'd0, vecs[i].rs1});
            check("vec_rf_rs2", {27'd0, rf_rs2}, {27'd0, vecs[i].rs2});
            tick();
            check("vec_ex_valid", {31'd0, ex_valid}, 32'd1);
            check("vec_ex_pc", ex_pc, 32'h1000 + 32'(i * 4));
            check("vec_ex_op_funct", {21'd0, ex_opcode, ex_funct}, {21'd0, w[6:0], vecs[i].funct});
            check("vec_ex_rd_rw_ill", {25'd0, ex_rd, ex_rw, ex_illegal},
                  {25'd0, vecs[i].rd, vecs[i].rw, vecs[i].ill});
            check("vec_ex_imm", ex_imm, vecs[i].imm);
            wb(vecs[i].rd);
        end

        // reset mid-operation with a held instruction, live ex and busy register
        ex_ready = 1'b0;
        send(32'h00500093, 32'h0100);
        tick();
        send(32'h00500093, 32'h0104);
        #2 reset = 1'b1;
        #1;
        check("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_ex_pc", ex_pc, 32'd0);
        check("arst_sb", dut.sb_q, 32'd0);
        check("arst_hold", {31'd0, dut.hold_full_q}, 32'd0);
        tick();
        reset = 1'b0; ex_ready = 1'b1;
        #1;
        check("arst_if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        check("arst_no_issue", {31'd0, ex_valid}, 32'd0);

        // RAW stall on x1
        send(32'h00500093, 32'h0200);
        if_valid = 1'b1; if_instr = 32'h00108133; if_pc = 32'h0204;
        tick();
        if_valid = 1'b0;
        check("raw_first_pc", ex_pc, 32'h0200);
        for (int k = 0; k < 3; k++) begin
            check("raw_rf", {22'd0, rf_rs1, rf_rs2}, {22'd0, 5'd1, 5'd1});
            check("raw_if_ready", {31'd0, if_ready}, 32'd0);
            tick();
            check("raw_stall", {31'd0, ex_valid}, 32'd0);
        end
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1;
`ifdef ID_WB_BYPASS_EN
        check("raw_wb_ready", {31'd0, if_ready}, 32'd1);
        tick(); wb_valid = 1'b0;
`else
        check("raw_wb_ready", {31'd0, if_ready}, 32'd0);
        tick(); wb_valid = 1'b0;
        check("raw_wb_still", {31'd0, ex_valid}, 32'd0);
        tick();
`endif
        check("raw_issue", {31'd0, ex_valid}, 32'd1);
        check("raw_issue_pc", ex_pc, 32'h0204);
        tick();
        wb(5'd2);

        // x0 destination never makes anything busy
        send(32'h00100013, 32'h0300);
        if_valid = 1'b1; if_instr = 32'h00000133; if_pc = 32'h0304;
        tick();
        if_valid = 1'b0;
        check("x0_rw_rd", {26'd0, ex_rw, ex_rd}, 32'd0);
        tick();
        check("x0_no_stall", {31'd0, ex_valid}, 32'd1);
        check("x0_no_stall_pc", ex_pc, 32'h0304);
        check("x0_sb", dut.sb_q, 32'h00000004);
        tick();
        wb(5'd2);

        // backpressure with two back-to-back instructions
        ex_ready = 1'b0;
        send(32'h00100513, 32'h0400);
        if_valid = 1'b1; if_instr = 32'h00200593; if_pc = 32'h0404;
        tick();
        if_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_if_ready", {31'd0, if_ready}, 32'd0);
            check("bp_stable", {ex_pc[15:0], 10'd0, ex_valid, ex_rd}, {16'h0400, 10'd0, 1'b1, 5'd10});
            tick();
        end
        ex_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, if_ready}, 32'd1);
        tick();
        check("bp_second", {ex_pc[15:0], 10'd0, ex_valid, ex_rd}, {16'h0404, 10'd0, 1'b1, 5'd11});
        check("bp_second_imm", ex_imm, 32'd2);
        tick();
        check("bp_drain", {31'd0, ex_valid}, 32'd0);
        wb(5'd10);
        wb(5'd11);

        // issue of lw x3 collides with writeback of x3
        send(32'hFFC12183, 32'h0500);
        wb(5'd3);
        check("coll_sb3", {31'd0, dut.sb_q[3]}, 32'd1);
        send(32'h00018233, 32'h0504);
        tick();
        check("coll_stall", {31'd0, ex_valid}, 32'd0);
        wb(5'd3);
        tick(); tick();
        wb(5'd4);

        // flush while execute is backpressured
        ex_ready = 1'b0;
        send(32'h00100513, 32'h0600);
        if_valid = 1'b1; if_instr = 32'h00200593; if_pc = 32'h0604;
        tick();
        if_instr = 32'h00300613; if_pc = 32'h0608;
        flush = 1'b1;
        #1;
        check("flush_if_ready", {31'd0, if_ready}, 32'd0);
        tick();
        flush = 1'b0; if_valid = 1'b0;
        check("flush_ex_kept", {ex_pc[15:0], 15'd0, ex_valid}, {16'h0600, 15'd0, 1'b1});
        check("flush_hold", {31'd0, dut.hold_full_q}, 32'd0);
        ex_ready = 1'b1;
        tick();
        check("flush_dropped", {31'd0, ex_valid}, 32'd0);
        wb(5'd10);

        // randomized run against the reference model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_held = 1'b0; m_exv = 1'b0; m_hi = 32'd0; m_hp = 32'd0; m_pc = 32'd0; m_imm = 32'd0;
        m_op = 7'd0; m_fn = 4'd0; m_rd = 5'd0; m_rw = 1'b0; m_ill = 1'b0; m_busy = 32'd0;
        for (int c = 0; c < 1500; c++) begin
            check("rnd_ex_valid", {31'd0, ex_valid}, {31'd0, m_exv});
            check("rnd_ex_fields", {14'd0, ex_rd, ex_rw, ex_illegal, ex_opcode, ex_funct},
                  {14'd0, m_rd, m_rw, m_ill, m_op, m_fn});
            check("rnd_ex_pc", ex_pc, m_pc);
            check("rnd_ex_imm", ex_imm, m_imm);
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 10)];
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if_instr = w;
            if_pc    = $urandom & 32'hFFFF_FFFC;
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_rd    = 5'($urandom_range(0, 7));
            md  = ref_decode(m_hi);
            eff = m_busy;
`ifdef ID_WB_BYPASS_EN
            if (wb_valid) eff[wb_rd] = 1'b0;
`endif
            hz  = (md.rs1 != 5'd0 && eff[md.rs1]) || (md.rs2 != 5'd0 && eff[md.rs2]);
            iss = m_held && !hz && !flush && (!m_exv || ex_ready);
            ifr = (!m_held || iss) && !flush;
            #1;
            check("rnd_if_ready", {31'd0, if_ready}, {31'd0, ifr});
            check("rnd_rf", {22'd0, rf_rs1, rf_rs2},
                  m_held ? {22'd0, md.rs1, md.rs2} : 32'd0);
            @(posedge clk);
            if (iss) begin
                m_exv = 1'b1; m_pc = m_hp; m_op = m_hi[6:0]; m_fn = {m_hi[30], m_hi[14:12]};
                m_rd = md.rd; m_rw = md.wr; m_imm = md.imm; m_ill = md.ill;
            end else if (ex_ready) begin
                m_exv = 1'b0;
            end
            if (wb_valid && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
            if (iss && md.wr) m_busy[md.rd] = 1'b1;
            if (if_valid && ifr) begin
                m_held = 1'b1; m_hi = if_instr; m_hp = if_pc;
            end else if (iss || flush) begin
                m_held = 1'b0;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
